// File: rtl/lif_synapse_driver.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// lif_synapse_driver
//
// Upstream driver for a LIF neuron's 8-bit input current. Weighted presynaptic
// events are accepted over a valid/ready handshake into a small FIFO. One event
// per cycle is popped (unless hold is high) and integrated into a saturating
// unsigned current. A free-running timer applies an exponential decay of
// current >> DECAY_SHIFT every DECAY_PERIOD cycles. A spike fed back from the
// neuron zeroes the current and opens a refractory window in which popped
// events are discarded.
//
// Ports:
//   clk         clock
//   reset       asynchronous, active-high reset
//   ev_valid    event offered
//   ev_ready    event accepted on ev_valid && ev_ready at a rising edge
//   ev_weight   signed two's-complement event weight
//   hold        stalls FIFO pops; decay keeps running
//   spike_fb    neuron spike feedback, single-cycle pulse
//   current     unsigned synaptic current (registered)
//   fifo_level  number of queued events (from registered pointers)
//   refractory  high while in the refractory state (registered)
// -----------------------------------------------------------------------------
module lif_synapse_driver #(
    parameter int FIFO_DEPTH     = 4,
    parameter int DECAY_PERIOD   = 16,
    parameter int DECAY_SHIFT    = 3,
    parameter int REFRACT_CYCLES = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          ev_valid,
    output logic                          ev_ready,
    input  logic [7:0]                    ev_weight,
    input  logic                          hold,
    input  logic                          spike_fb,
    output logic [7:0]                    current,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          refractory
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int PW = AW + 1;
    localparam int TW = $clog2(DECAY_PERIOD);
    localparam int CW = (REFRACT_CYCLES > 1) ? $clog2(REFRACT_CYCLES) : 1;

    localparam logic [PW-1:0] LEVEL_FULL = PW'(FIFO_DEPTH);
    localparam logic [TW-1:0] TIMER_LAST = TW'(DECAY_PERIOD - 1);
    localparam logic [CW-1:0] CNT_RELOAD = CW'(REFRACT_CYCLES - 1);

    typedef enum logic {
        ST_RUN     = 1'b0,
        ST_REFRACT = 1'b1
    } state_e;

    // Clamp a signed intermediate into the unsigned 8-bit current range.
    function automatic logic [7:0] clamp_u8(input logic signed [9:0] v);
        logic [7:0] r;
        if (v < 10'sd0) begin
            r = 8'd0;
        end else if (v > 10'sd255) begin
            r = 8'd255;
        end else begin
            r = v[7:0];
        end
        return r;
    endfunction

    // FIFO storage and pointers (extra MSB distinguishes full from empty)
    logic [7:0]     mem_q [FIFO_DEPTH];
    logic [PW-1:0]  wr_ptr_q;
    logic [PW-1:0]  rd_ptr_q;
    logic [PW-1:0]  level_s;
    logic           full_s;
    logic           empty_s;
    logic           push_s;
    logic           pop_s;
    logic [7:0]     head_s;

    // Decay timer
    logic [TW-1:0]  timer_q;
    logic           tick_s;

    // Integrator / refractory state
    state_e         state_q;
    logic [CW-1:0]  cnt_q;
    logic [7:0]     current_q;
    logic           refractory_q;
    logic [7:0]     current_d;

    logic signed [9:0] cur_ext_s;
    logic signed [9:0] decay_s;
    logic signed [9:0] add_s;
    logic signed [9:0] sum_s;

    assign level_s    = wr_ptr_q - rd_ptr_q;
    assign full_s     = (level_s == LEVEL_FULL);
    assign empty_s    = (level_s == {PW{1'b0}});
    assign ev_ready   = !full_s && !reset;
    // Push is gated by full alone: a same-cycle pop does not make room.
    assign push_s     = ev_valid && ev_ready;
    assign pop_s      = !empty_s && !hold;
    assign head_s     = mem_q[rd_ptr_q[AW-1:0]];
    assign tick_s     = (timer_q == TIMER_LAST);

    assign current    = current_q;
    assign refractory = refractory_q;
    assign fifo_level = level_s;

    // FIFO data write (storage needs no reset; pointers define validity)
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_q[wr_ptr_q[AW-1:0]] <= ev_weight;
        end
    end

    // FIFO pointer update
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= {PW{1'b0}};
            rd_ptr_q <= {PW{1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_q <= wr_ptr_q + PW'(1);
            end
            if (pop_s) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
        end
    end

    // Free-running decay timer, active in every state
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            timer_q <= {TW{1'b0}};
        end else if (tick_s) begin
            timer_q <= {TW{1'b0}};
        end else begin
            timer_q <= timer_q + TW'(1);
        end
    end

    // Next integrated current: decay uses the pre-update value, then the
    // popped weight is added, all in a signed 10-bit range before clamping.
    always_comb begin
        cur_ext_s = $signed({2'b00, current_q});
        if (tick_s) begin
            decay_s = cur_ext_s >>> DECAY_SHIFT;
        end else begin
            decay_s = 10'sd0;
        end
        if (pop_s) begin
            add_s = $signed({{2{head_s[7]}}, head_s});
        end else begin
            add_s = 10'sd0;
        end
        sum_s     = cur_ext_s - decay_s + add_s;
        current_d = clamp_u8(sum_s);
    end

    // RUN/REFRACT state machine with registered current and refractory flag.
    // spike_fb wins over decay and event add; events popped while the spike
    // is taken or during REFRACT are simply dropped.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_RUN;
            cnt_q        <= {CW{1'b0}};
            current_q    <= 8'd0;
            refractory_q <= 1'b0;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (spike_fb) begin
                        current_q    <= 8'd0;
                        cnt_q        <= CNT_RELOAD;
                        state_q      <= ST_REFRACT;
                        refractory_q <= 1'b1;
                    end else begin
                        current_q    <= current_d;
                    end
                end
                ST_REFRACT: begin
                    current_q <= 8'd0;
                    if (spike_fb) begin
                        cnt_q <= CNT_RELOAD;
                    end else if (cnt_q == {CW{1'b0}}) begin
                        state_q      <= ST_RUN;
                        refractory_q <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                default: begin
                    state_q      <= ST_RUN;
                    cnt_q        <= {CW{1'b0}};
                    current_q    <= 8'd0;
                    refractory_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lif_synapse_driver.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_lif_synapse_driver
//
// Scoreboard bench. The driver applies stimulus once per cycle and, at each
// rising edge, advances a behavioural model (queue of weights, integer current,
// remaining-refractory count, decay timer) and pushes the expected outputs.
// A monitor on the falling edge pops each expectation and compares it with the
// DUT. A few directed scenario checks compare against hand-derived constants.
// -----------------------------------------------------------------------------
module tb_lif_synapse_driver;

    localparam int FIFO_DEPTH     = 4;
    localparam int DECAY_PERIOD   = 16;
    localparam int DECAY_SHIFT    = 3;
    localparam int REFRACT_CYCLES = 8;
    localparam int PW             = $clog2(FIFO_DEPTH) + 1;

    logic          clk       = 1'b0;
    logic          reset     = 1'b1;
    logic          ev_valid  = 1'b0;
    logic [7:0]    ev_weight = 8'd0;
    logic          hold      = 1'b0;
    logic          spike_fb  = 1'b0;
    logic          ev_ready;
    logic [7:0]    current;
    logic [PW-1:0] fifo_level;
    logic          refractory;

    lif_synapse_driver #(
        .FIFO_DEPTH     (FIFO_DEPTH),
        .DECAY_PERIOD   (DECAY_PERIOD),
        .DECAY_SHIFT    (DECAY_SHIFT),
        .REFRACT_CYCLES (REFRACT_CYCLES)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .ev_valid   (ev_valid),
        .ev_ready   (ev_ready),
        .ev_weight  (ev_weight),
        .hold       (hold),
        .spike_fb   (spike_fb),
        .current    (current),
        .fifo_level (fifo_level),
        .refractory (refractory)
    );

    always #5 clk = ~clk;

    typedef struct {
        int cur;
        int lvl;
        bit refr;
        bit rdy;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Behavioural model state
    int   m_fifo[$];
    int   m_cur       = 0;
    int   m_refr_left = 0;
    int   m_tmr       = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic model_reset();
        m_fifo.delete();
        m_cur       = 0;
        m_refr_left = 0;
        m_tmr       = 0;
    endtask

    // One clock edge of the reference behaviour, using the inputs as sampled.
    task automatic model_step();
        exp_t e;
        int   w;
        bit   tick;
        bit   do_push;
        bit   do_pop;
        if (reset) begin
            model_reset();
        end else begin
            do_push = ev_valid && (m_fifo.size() < FIFO_DEPTH);
            do_pop  = (m_fifo.size() > 0) && !hold;
            w = 0;
            if (do_pop) w = m_fifo.pop_front();
            if (do_push) m_fifo.push_back(int'($signed(ev_weight)));
            tick  = (m_tmr == DECAY_PERIOD - 1);
            m_tmr = (m_tmr + 1) % DECAY_PERIOD;
            if (spike_fb) begin
                m_cur       = 0;
                m_refr_left = REFRACT_CYCLES;
            end else if (m_refr_left > 0) begin
                m_refr_left--;
                m_cur = 0;
            end else begin
                m_cur = m_cur - (tick ? (m_cur / (1 << DECAY_SHIFT)) : 0) + w;
                if (m_cur < 0)   m_cur = 0;
                if (m_cur > 255) m_cur = 255;
            end
        end
        e.cur  = m_cur;
        e.lvl  = m_fifo.size();
        e.refr = (m_refr_left > 0);
        e.rdy  = (m_fifo.size() < FIFO_DEPTH);
        sb.push_back(e);
    endtask

    task automatic cycle(input bit v, input int w, input bit h, input bit s);
        ev_valid  = v;
        ev_weight = 8'(w);
        hold      = h;
        spike_fb  = s;
        @(posedge clk);
        model_step();
        #1;
    endtask

    // Called at posedge+1: asserts reset between edges and checks it acts at once.
    task automatic async_reset_check();
        #1 reset = 1'b1;
        #1;
        check("rst_async_current", current, 0);
        check("rst_async_level", fifo_level, 0);
        check("rst_async_ready", ev_ready, 0);
        check("rst_async_refr", refractory, 0);
        sb.delete();
        model_reset();
    endtask

    // Monitor: compare every presented output against the next expectation.
    always @(negedge clk) begin
        exp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check("current", current, e.cur);
            check("fifo_level", fifo_level, e.lvl);
            check("refractory", refractory, e.refr);
            if (!reset) check("ev_ready", ev_ready, e.rdy);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        reset = 1'b1;
        repeat (3) cycle(0, 0, 0, 0);
        check("reset_ready", ev_ready, 0);
        reset = 1'b0;

        // Single event, one-cycle pop latency
        cycle(0, 0, 0, 0);
        cycle(1, 40, 0, 0);
        check("w40_level_queued", fifo_level, 1);
        cycle(0, 0, 0, 0);
        check("w40_current", current, 40);
        check("w40_level", fifo_level, 0);
        repeat (10) cycle(0, 0, 0, 0);
        check("w40_hold", current, 40);

        // Negative clamp and positive saturation
        cycle(1, -128, 0, 0);
        cycle(1, 127, 0, 0);
        check("neg_clamp", current, 0);
        cycle(1, 127, 0, 0);
        check("sat_127", current, 127);
        cycle(1, 127, 0, 0);
        cycle(0, 0, 0, 0);
        check("sat_255", current, 255);

        // Load 200 then watch three decay ticks (edges 32, 48, 64 after release)
        cycle(1, -128, 0, 0);
        cycle(1, -128, 0, 0);
        cycle(1, 127, 0, 0);
        cycle(1, 73, 0, 0);
        cycle(0, 0, 0, 0);
        check("load_200", current, 200);
        repeat (9) cycle(0, 0, 0, 0);
        check("decay_175", current, 175);
        repeat (16) cycle(0, 0, 0, 0);
        check("decay_154", current, 154);
        repeat (16) cycle(0, 0, 0, 0);
        check("decay_135", current, 135);

        // Backpressure with hold
        for (int i = 0; i < 6; i++) cycle(1, 10 + i, 1, 0);
        check("bp_level", fifo_level, 4);
        check("bp_ready", ev_ready, 0);
        repeat (5) cycle(0, 0, 0, 0);
        check("bp_drained", fifo_level, 0);

        // Refractory window with a discarded event inside it
        cycle(0, 0, 0, 1);
        check("refr_zero", current, 0);
        check("refr_on", refractory, 1);
        for (int i = 1; i < REFRACT_CYCLES; i++) cycle(i == 3, 30, 0, 0);
        check("refr_last", refractory, 1);
        check("refr_discard", current, 0);
        cycle(0, 0, 0, 0);
        check("refr_off", refractory, 0);
        cycle(1, 30, 0, 0);
        cycle(0, 0, 0, 0);
        check("refr_after", current, 30);

        // Second spike extends the window
        cycle(0, 0, 0, 1);
        repeat (4) cycle(0, 0, 0, 0);
        cycle(0, 0, 0, 1);
        repeat (REFRACT_CYCLES - 1) cycle(0, 0, 0, 0);
        check("ext_last", refractory, 1);
        cycle(0, 0, 0, 0);
        check("ext_off", refractory, 0);

        // Reset mid-operation with queued events
        cycle(1, 90, 0, 0);
        cycle(1, 5, 0, 0);
        cycle(1, 6, 1, 0);
        cycle(1, 7, 1, 0);
        check("pre_rst_level", fifo_level, 3);
        async_reset_check();
        repeat (2) cycle(0, 0, 0, 0);
        reset = 1'b0;
        repeat (5) cycle(0, 0, 0, 0);
        check("post_rst_current", current, 0);

        // Randomized traffic
        for (int i = 0; i < 800; i++) begin
            cycle($urandom_range(0, 1) == 1, int'($urandom_range(0, 255)),
                  $urandom_range(0, 3) == 0, $urandom_range(0, 40) == 0);
        end
        repeat (12) cycle(0, 0, 0, 0);

        // Let the monitor consume the last expectation
        @(negedge clk);
        #1;
        check("sb_drained", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/lif_synapse_driver.md
Name: lif_synapse_driver

Overview:
Upstream driver for the LIF neuron's 8-bit input current. It accepts weighted presynaptic spike events over a valid/ready handshake and buffers them in a small FIFO. It integrates the events into a saturating synaptic current with periodic exponential decay. A neuron spike fed back on spike_fb zeroes the current and starts a refractory window, during which arriving events are discarded.

Parameters:
FIFO_DEPTH, 4, event FIFO entries; power of 2, at least 2
DECAY_PERIOD, 16, cycles between decay ticks; at least 2
DECAY_SHIFT, 3, decay amount is current >> DECAY_SHIFT at each tick
REFRACT_CYCLES, 8, refractory length in cycles; at least 1

Ports:
clk  input  1  clock
reset  input  1  asynchronous, active-high reset
ev_valid  input  1  event offered
ev_ready  output  1  event accepted when ev_valid && ev_ready at a rising edge
ev_weight  input  8  signed two's-complement weight (-128..+127)
hold  input  1  stalls FIFO pops; decay still runs
spike_fb  input  1  neuron spike feedback, single-cycle pulse
current  output  8  unsigned synaptic current to the neuron
fifo_level  output  $clog2(FIFO_DEPTH)+1  number of queued events
refractory  output  1  high while in REFRACT state

Behaviour:
- Reset (asynchronous): current=0, FIFO empty, fifo_level=0, state=RUN, refractory=0, decay timer=0, refractory counter=0.
- ev_ready = !full && !reset (combinational).
- No push when full, even if a pop occurs in the same cycle.
- Push and pop in the same cycle are allowed when not full; fifo_level is then unchanged.
- Pop: at most one event per cycle, when FIFO is non-empty and hold=0. Pops occur in both RUN and REFRACT.
- Latency: an event accepted at edge k is popped at edge k+1 (if the FIFO was empty and hold=0). It is reflected in current after edge k+1.
- Decay timer: free-running count 0..DECAY_PERIOD-1. tick = (timer == DECAY_PERIOD-1). Runs in both states.
- RUN update per cycle, computed in a signed 10-bit intermediate:
  - nxt = current - (tick ? current>>DECAY_SHIFT : 0) + (pop ? sext(ev_weight_head) : 0)
  - Clamp nxt to [0,255].
  - Decay is computed on the pre-update current; decay and event add are combined in one cycle.
- States:
  - RUN: spike_fb=1 → current<=0, counter<=REFRACT_CYCLES-1, go to REFRACT. Any event popped that cycle is discarded.
  - REFRACT: current held at 0; popped events are discarded; refractory=1.
    - Counter decrements each cycle.
    - Counter==0 with no spike_fb → RUN.
    - spike_fb in REFRACT reloads the counter to REFRACT_CYCLES-1.
- Refractory window: exactly REFRACT_CYCLES cycles with refractory=1 after the spike_fb edge. The first event applied is one popped on the first RUN cycle.
- spike_fb has priority over the event add and decay in the same cycle.
- Reset mid-operation: queued events are lost; all outputs return to reset values immediately.
- Outputs current, refractory and fifo_level are registered (fifo_level is derived from the registered pointers).

Test Plan:
- Reset released, push w=+40 at edge 5 → current=40 after edge 6, fifo_level returns to 0; current holds 40 until the next tick.
- Load current=200, no events, DECAY_SHIFT=3 → ticks give 175, then 154, then 135, one value every 16 cycles.
- Saturation: from 0, push +127 three times on consecutive cycles → 127, 254, 255. From 50, push -128 → 0.
- Backpressure: hold=1, ev_valid held for 6 cycles → 4 accepted, ev_ready=0, fifo_level=4. Release hold → one pop per cycle, fifo_level 3,2,1,0, ev_ready=1 after the first pop.
- Refractory: current=180, spike_fb pulse → current=0 next cycle and refractory=1 for 8 cycles. A +30 event pushed at cycle 3 is discarded. A +30 pushed after the window gives current=30. A second spike_fb at cycle 5 extends the window to 8 cycles from that pulse.
- Reset mid-operation: 3 queued events and current=90, assert reset asynchronously → current=0, fifo_level=0 immediately, ev_ready=0 during reset. After release, no stale events are applied.
